// File: rtl/jericalla_pkg.sv
// Shared definitions for the Jericalla instruction sequencer.
// Instruction word layout (17 bits):
//   [16:13] DirRAM | [12:9] OP | [8:5] DirROMA | [4:1] DirROMB | [0] RW
// RW=1 requests a RAM write in the datapath; RW=0 is a read.
package jericalla_pkg;

    localparam int BUS_W        = 17;

    localparam int RAM_ADDR_MSB = 16;
    localparam int RAM_ADDR_LSB = 13;
    localparam int OP_MSB       = 12;
    localparam int OP_LSB       = 9;
    localparam int ROMA_MSB     = 8;
    localparam int ROMA_LSB     = 5;
    localparam int ROMB_MSB     = 4;
    localparam int ROMB_LSB     = 1;
    localparam int RW_BIT       = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/jericalla_sequencer_prog_mem.sv
// Program memory for the Jericalla sequencer.
// DEPTH x BUS_W words, one synchronous write port, one combinational read
// port. Contents are not reset.
// Ports:
//   clk     - rising-edge clock
//   we      - write enable
//   wr_addr - write address
//   wr_data - write data
//   rd_addr - read address
//   rd_data - read data (combinational)
module jericalla_sequencer_prog_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int BUS_W  = 17
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BUS_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BUS_W-1:0]  rd_data
);

    logic [BUS_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/jericalla_sequencer.sv
// Jericalla instruction sequencer: stores a short program of instruction
// words and replays them on the datapath bus, each word held HOLD_CYCLES
// cycles. The first cycle of every word has RW masked low so the ROM/ALU
// path settles before any RAM write strobe is raised.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   load_en/addr/data     - program memory write (only while idle)
//   prog_len              - words to run (clamped to DEPTH), sampled at start
//   stop_on_zero          - end run when zflg is high, sampled at start
//   start                 - run request (ignored unless idle)
//   zflg                  - zero flag from the datapath
//   bus_out               - registered instruction bus
//   pc                    - index of word on the bus
//   busy / done / zero_hit- run status
module jericalla_sequencer #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int BUS_W       = jericalla_pkg::BUS_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [BUS_W-1:0]  load_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              stop_on_zero,
    input  logic              start,
    input  logic              zflg,
    output logic [BUS_W-1:0]  bus_out,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic              zero_hit
);

    import jericalla_pkg::*;

    localparam int              HOLD_W    = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W + 1)'(DEPTH);

    state_t              state_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    logic [ADDR_W-1:0]   last_idx_reg;
    logic                stop_on_zero_reg;

    logic                mem_we;
    logic [ADDR_W-1:0]   rd_addr;
    logic [BUS_W-1:0]    rd_data;
    logic [BUS_W-1:0]    next_word;
    logic [BUS_W-1:0]    next_word_masked;
    logic                hold_last;
    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   len_last;

    assign mem_we = load_en && (state_reg == IDLE);

    jericalla_sequencer_prog_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .BUS_W  (BUS_W)
    ) u_prog_mem (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        hold_last = (hold_cnt_reg == HOLD_LAST);
        pc_inc    = pc + 1'b1;

        // Look ahead: on the last hold cycle fetch the next word so it can be
        // registered onto the bus without a gap cycle.
        rd_addr = pc;
        if (state_reg == IDLE) begin
            rd_addr = '0;
        end else if (hold_last) begin
            rd_addr = pc_inc;
        end

        // A load to word 0 in the start cycle must be visible to the run,
        // but the array only updates at the same edge, so forward it.
        next_word = rd_data;
        if (state_reg == IDLE && load_en && load_addr == '0) begin
            next_word = load_data;
        end
        next_word_masked         = next_word;
        next_word_masked[RW_BIT] = 1'b0;

        len_last = (prog_len > DEPTH_LEN) ? ADDR_W'(DEPTH - 1)
                                          : ADDR_W'(prog_len - 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            bus_out          <= '0;
            pc               <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            zero_hit         <= 1'b0;
            hold_cnt_reg     <= '0;
            last_idx_reg     <= '0;
            stop_on_zero_reg <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        zero_hit         <= 1'b0;
                        stop_on_zero_reg <= stop_on_zero;
                        last_idx_reg     <= len_last;
                        pc               <= '0;
                        hold_cnt_reg     <= '0;
                        if (prog_len == '0) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= ISSUE;
                            busy      <= 1'b1;
                            bus_out   <= next_word_masked;
                        end
                    end
                end
                ISSUE: begin
                    if (!hold_last) begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                        bus_out      <= rd_data;
                    end else if ((stop_on_zero_reg && zflg) || (pc == last_idx_reg)) begin
                        zero_hit     <= zero_hit | (stop_on_zero_reg && zflg);
                        state_reg    <= DONE;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        bus_out      <= '0;
                        pc           <= '0;
                        hold_cnt_reg <= '0;
                    end else begin
                        pc           <= pc_inc;
                        hold_cnt_reg <= '0;
                        bus_out      <= next_word_masked;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
